// File: rtl/uart_xform_pkg.sv
// Shared encodings and the byte transform used by the UART transform FIFO.
// The transform is a pure function so the top can apply it at write time.
package uart_xform_pkg;

    localparam logic [1:0] MODE_PASS  = 2'd0;
    localparam logic [1:0] MODE_ROT   = 2'd1;
    localparam logic [1:0] MODE_UPPER = 2'd2;
    localparam logic [1:0] MODE_LOWER = 2'd3;

    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_UPPER_Z = 8'h5A;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
    localparam logic [7:0] CASE_OFFSET   = 8'h20;

    typedef enum logic [1:0] {
        StIdle,
        StWaitBusy,
        StWaitDone
    } tx_state_e;

    function automatic logic [7:0] xform_byte(input logic [1:0] mode,
                                              input logic [4:0] rot_n,
                                              input logic [7:0] c);
        logic       is_upper;
        logic       is_lower;
        logic [7:0] base;
        logic [5:0] rotated;
        is_upper = (c >= ASCII_UPPER_A) && (c <= ASCII_UPPER_Z);
        is_lower = (c >= ASCII_LOWER_A) && (c <= ASCII_LOWER_Z);
        base     = is_upper ? ASCII_UPPER_A : ASCII_LOWER_A;
        // Offset (0..25) plus rot_n (0..25) stays below 64, so one subtract wraps it.
        rotated  = 6'(c - base) + 6'(rot_n);
        if (rotated >= 6'd26) begin
            rotated = rotated - 6'd26;
        end
        xform_byte = c;
        case (mode)
            MODE_PASS:  xform_byte = c;
            MODE_ROT:   if (is_upper || is_lower) xform_byte = base + {2'b00, rotated};
            MODE_UPPER: if (is_lower) xform_byte = c - CASE_OFFSET;
            MODE_LOWER: if (is_upper) xform_byte = c + CASE_OFFSET;
        endcase
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Single-clock byte FIFO with extended pointers; occupancy is kept in a register.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module byte_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clock_12mhz,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [7:0]            din,
    output logic [7:0]            dout,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    logic [7:0]          mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0] count_q;
    logic                do_push;
    logic                do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clock_12mhz) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= wr_ptr_d - rd_ptr_d;
        end
    end

    always_ff @(posedge clock_12mhz) begin
        if (do_push) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign count = count_q;

endmodule

// File: rtl/uart_xform_fifo.sv
// Buffered, mode-selectable character transform between a UART receiver and transmitter,
// with drop accounting and a transmit FSM that waits for the transmitter's busy flag.
module uart_xform_fifo #(
    parameter int unsigned DEPTH_LOG2   = 4,
    parameter int unsigned ROT_N        = 13,
    parameter int unsigned BUSY_TIMEOUT = 3
) (
    input  logic                  clock_12mhz,
    input  logic                  reset,
    input  logic [1:0]            mode,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [7:0]            tx_byte,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic [7:0]            drop_count
);

    import uart_xform_pkg::*;

    tx_state_e  state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic       pop;
    logic       push;
    logic       drop;
    logic [7:0] wr_byte;
    logic [7:0] fifo_dout;
    logic       fifo_full;
    logic       fifo_empty;
    logic       tx_start_q;
    logic [7:0] tx_byte_q;
    logic       overflow_q;
    logic [7:0] drop_count_q;

    // Transform at write time so later mode changes leave queued bytes alone.
    assign wr_byte = xform_byte(mode, 5'(ROT_N), rx_byte);
    assign push    = rx_valid && (!fifo_full || pop);
    assign drop    = rx_valid && fifo_full && !pop;

    byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clock_12mhz (clock_12mhz),
        .reset       (reset),
        .push        (push),
        .pop         (pop),
        .din         (wr_byte),
        .dout        (fifo_dout),
        .count       (count),
        .full        (fifo_full),
        .empty       (fifo_empty)
    );

    always_ff @(posedge clock_12mhz) begin
        if (reset) begin
            state_q <= StIdle;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    state_d = StWaitBusy;
                    timer_d = '0;
                end
            end
            StWaitBusy: begin
                if (tx_busy) begin
                    state_d = StWaitDone;
                end else begin
                    // Guards against a transmitter that finishes without showing busy.
                    timer_d = timer_q + 8'd1;
                    if (timer_d == 8'(BUSY_TIMEOUT)) state_d = StIdle;
                end
            end
            StWaitDone: begin
                if (!tx_busy) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pop = (state_q == StIdle) && !fifo_empty && !tx_busy;
    end

    always_ff @(posedge clock_12mhz) begin
        if (reset) begin
            tx_start_q   <= 1'b0;
            tx_byte_q    <= 8'h00;
            overflow_q   <= 1'b0;
            drop_count_q <= 8'h00;
        end else begin
            tx_start_q <= pop;
            if (pop) tx_byte_q <= fifo_dout;
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_count_q != 8'hFF) drop_count_q <= drop_count_q + 8'd1;
            end
        end
    end

    assign tx_start   = tx_start_q;
    assign tx_byte    = tx_byte_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule
